branch_condition_checker: RTL and testbench

- Branch-resolution block in the ID stage of the 5-stage pipeline processor.
- Compares two register-file read values under a 2-bit branch command from the control unit.
- Asserts the branch-taken condition combinationally, so the same cycle can redirect PC and flush IF.
- Also provides a registered copy of the condition and a taken-branch counter for debug and performance.

---
 rtl/branch_condition_checker.sv | 50 +++++
 tb/tb_branch_condition_checker.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/branch_condition_checker.sv
// Branch-resolution block for the ID stage: evaluates the branch condition
// combinationally from two operands and a 2-bit command, and keeps a
// registered copy of the condition plus a saturating taken-branch counter.
module branch_condition_checker #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] reg1,
  input  logic [DATA_WIDTH-1:0] reg2,
  input  logic [1:0]            cuBranchComm,
  output logic                  brCond,
  output logic                  brCondReg,
  output logic [CNT_WIDTH-1:0]  brCount
);

  localparam logic [1:0] CMD_NONE = 2'b00;
  localparam logic [1:0] CMD_BEZ  = 2'b01;
  localparam logic [1:0] CMD_BNE  = 2'b10;
  localparam logic [1:0] CMD_JMP  = 2'b11;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  // Branch-taken decode; same-cycle result so IF can be redirected and flushed.
  always_comb begin
    brCond = 1'b0;
    unique case (cuBranchComm)
      CMD_NONE: brCond = 1'b0;
      CMD_BEZ:  brCond = (reg1 == '0);
      CMD_BNE:  brCond = (reg1 != reg2);
      CMD_JMP:  brCond = 1'b1;
      default:  brCond = 1'b0;
    endcase
  end

  // Debug copy of the condition and saturating taken-branch counter; reset wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      brCondReg <= 1'b0;
      brCount   <= '0;
    end else begin
      brCondReg <= brCond;
      if (brCond && (brCount != CNT_MAX)) begin
        brCount <= brCount + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_branch_condition_checker.sv
// Scoreboard bench: the driver pushes the expected view of both instances
// (default counter width and a 4-bit counter) for every cycle it drives;
// an independent monitor pops and compares against the DUT outputs.
module tb_branch_condition_checker;

  logic        clk;
  logic        rst;
  logic [31:0] reg1;
  logic [31:0] reg2;
  logic [1:0]  cmd;

  logic        br_cond;
  logic        br_cond_reg;
  logic [15:0] br_count;
  logic        br_cond4;
  logic        br_cond_reg4;
  logic [3:0]  br_count4;

  int tests = 0;
  int fails = 0;

  branch_condition_checker #(.DATA_WIDTH(32), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .reg1(reg1), .reg2(reg2), .cuBranchComm(cmd),
    .brCond(br_cond), .brCondReg(br_cond_reg), .brCount(br_count)
  );

  branch_condition_checker #(.DATA_WIDTH(32), .CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .reg1(reg1), .reg2(reg2), .cuBranchComm(cmd),
    .brCond(br_cond4), .brCondReg(br_cond_reg4), .brCount(br_count4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit cond;
    bit known;
    bit creg;
    int cnt;
    int cnt4;
  } exp_t;

  exp_t sb[$];

  // Reference state as seen after the most recent rising edge.
  bit m_known = 1'b0;
  bit m_creg  = 1'b0;
  int m_cnt   = 0;
  int m_cnt4  = 0;

  // Branch rule straight from the command table.
  function automatic bit model_cond(input logic [31:0] a, input logic [31:0] b,
                                    input logic [1:0] c);
    case (c)
      2'd0: return 1'b0;
      2'd1: return (a == 32'd0);
      2'd2: return (a != b);
      default: return 1'b1;
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int expv);
    tests++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  // One cycle of stimulus: drive after the falling edge, record expectation,
  // then advance the reference state across the coming rising edge.
  task automatic step(input bit r, input logic [31:0] a, input logic [31:0] b,
                      input logic [1:0] c);
    exp_t e;
    @(negedge clk);
    rst  = r;
    reg1 = a;
    reg2 = b;
    cmd  = c;
    #1;
    e.cond  = model_cond(a, b, c);
    e.known = m_known;
    e.creg  = m_creg;
    e.cnt   = m_cnt;
    e.cnt4  = m_cnt4;
    sb.push_back(e);
    if (r) begin
      m_known = 1'b1;
      m_creg  = 1'b0;
      m_cnt   = 0;
      m_cnt4  = 0;
    end else begin
      m_creg = e.cond;
      if (e.cond) begin
        m_cnt  = (m_cnt  < 65535) ? m_cnt + 1  : m_cnt;
        m_cnt4 = (m_cnt4 < 15)    ? m_cnt4 + 1 : m_cnt4;
      end
    end
  endtask

  // Monitor: compares every pending expectation against the live outputs.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      while (sb.size() > 0) begin
        e = sb.pop_front();
        chk("brCond", int'(br_cond), int'(e.cond));
        chk("brCond_w4", int'(br_cond4), int'(e.cond));
        if (e.known) begin
          chk("brCondReg", int'(br_cond_reg), int'(e.creg));
          chk("brCondReg_w4", int'(br_cond_reg4), int'(e.creg));
          chk("brCount", int'(br_count), e.cnt);
          chk("brCount_w4", int'(br_count4), e.cnt4);
        end
      end
    end
  end

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    rst  = 1'b1;
    reg1 = '0;
    reg2 = '0;
    cmd  = 2'b00;

    // Reset for two cycles.
    step(1, 32'd0, 32'd0, 2'b00);
    step(1, 32'd0, 32'd0, 2'b00);

    // NONE / BNE / NONE.
    step(0, 32'd0, 32'd13, 2'b00);
    step(0, 32'd0, 32'd13, 2'b10);
    step(0, 32'd0, 32'd13, 2'b00);

    // JMP ignores operands.
    step(0, 32'd1, 32'd13, 2'b11);
    step(0, 32'd0, 32'd13, 2'b11);

    // BEZ and BNE edge cases.
    step(0, 32'd0, 32'd13, 2'b01);
    step(0, 32'd13, 32'd13, 2'b01);
    step(0, 32'd13, 32'd13, 2'b10);
    step(0, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 2'b10);

    // Reset, five JMP cycles, then idle: count lands on 5.
    step(1, 32'd0, 32'd0, 2'b00);
    step(1, 32'd0, 32'd0, 2'b00);
    repeat (5) step(0, 32'd0, 32'd0, 2'b11);
    repeat (3) step(0, 32'd0, 32'd0, 2'b00);

    // Saturation of the 4-bit counter, then reset while the branch is taken.
    repeat (20) step(0, 32'd5, 32'd9, 2'b11);
    step(1, 32'd5, 32'd9, 2'b11);
    repeat (2) step(0, 32'd5, 32'd9, 2'b11);

    // Randomised operands and commands with occasional reset.
    for (int i = 0; i < 1000; i++) begin
      a = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom);
      b = ($urandom_range(0, 2) == 0) ? a : 32'($urandom);
      step($urandom_range(0, 49) == 0, a, b, 2'($urandom_range(0, 3)));
    end

    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
